// File: rtl/control_if.sv
// Memory request/response bundle between the control FSM and the memory port.
interface control_if;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;
  logic       mem_resp;

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    output mem_resp
  );
endinterface

// File: rtl/control.sv
// Moore control FSM for a 16-bit fetch/decode/execute datapath.
// Optional memory-wait watchdog enabled by defining MEM_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH1    | MAR <- PC, PC <- PC+2
// FETCH2    | read instruction word into MDR, wait mem_resp
// FETCH3    | IR <- MDR
// DECODE    | dispatch on opcode (unknown opcode = NOP)
// S_ADD     | regfile <- A + B, update CC
// S_AND     | regfile <- A & B, update CC
// S_NOT     | regfile <- ~A, update CC
// BR        | test br_enable
// BR_TAKEN  | PC <- branch target
// CALC_ADDR | MAR <- base + offset
// LDR1      | read data into MDR, wait mem_resp
// LDR2      | regfile <- MDR, update CC
// STR1      | MDR <- store register (ALU pass-through)
// STR2      | write MDR to memory, wait mem_resp
module control #(
  parameter int TIMEOUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             br_enable,
  control_if.master        mem,
  output logic             load_pc,
  output logic             load_ir,
  output logic             load_regfile,
  output logic             load_mar,
  output logic             load_mdr,
  output logic             load_cc,
  output logic             pcmux_sel,
  output logic             storemux_sel,
  output logic             alumux_sel,
  output logic             regfilemux_sel,
  output logic             marmux_sel,
  output logic             mdrmux_sel,
  output logic [2:0]       aluop,
  output logic             mem_timeout
);

  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("control: TIMEOUT_W must be at least 1");
  end

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, BR, BR_TAKEN,
    CALC_ADDR, LDR1, LDR2, STR1, STR2
  } state_e;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic       pcmux_sel;
    logic       storemux_sel;
    logic       alumux_sel;
    logic       regfilemux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_NOT  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Outputs are a pure function of state; they are registered by decoding the next state.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH1:    begin c.load_mar = 1'b1; c.marmux_sel = 1'b1; c.load_pc = 1'b1; end
      FETCH2:    begin c.mem_read = 1'b1; c.load_mdr = 1'b1; c.mdrmux_sel = 1'b1; end
      FETCH3:    c.load_ir = 1'b1;
      S_ADD:     begin c.load_regfile = 1'b1; c.load_cc = 1'b1; c.aluop = ALU_ADD; end
      S_AND:     begin c.load_regfile = 1'b1; c.load_cc = 1'b1; c.aluop = ALU_AND; end
      S_NOT:     begin c.load_regfile = 1'b1; c.load_cc = 1'b1; c.aluop = ALU_NOT; end
      BR_TAKEN:  begin c.load_pc = 1'b1; c.pcmux_sel = 1'b1; end
      CALC_ADDR: begin c.alumux_sel = 1'b1; c.aluop = ALU_ADD; c.load_mar = 1'b1; end
      LDR1:      begin c.mem_read = 1'b1; c.load_mdr = 1'b1; c.mdrmux_sel = 1'b1; end
      LDR2:      begin c.regfilemux_sel = 1'b1; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      STR1:      begin c.storemux_sel = 1'b1; c.aluop = ALU_PASS; c.load_mdr = 1'b1; end
      STR2:      c.mem_write = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

`ifdef MEM_TIMEOUT_EN
  // Down-counter loaded so that it hits zero on the (2^W-1)th idle wait cycle.
  localparam logic [TIMEOUT_W-1:0] TIMER_LOAD = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic                 waiting;
  logic                 timeout_hit;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH1:    state_d = FETCH2;
      FETCH2:    if (mem.mem_resp) state_d = FETCH3;
      FETCH3:    state_d = DECODE;
      DECODE: begin
        case (opcode)
          4'b0001:          state_d = S_ADD;
          4'b0101:          state_d = S_AND;
          4'b1001:          state_d = S_NOT;
          4'b0000:          state_d = BR;
          4'b0110, 4'b0111: state_d = CALC_ADDR;
          default:          state_d = FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: state_d = FETCH1;
      BR:        state_d = br_enable ? BR_TAKEN : FETCH1;
      BR_TAKEN:  state_d = FETCH1;
      CALC_ADDR: state_d = (opcode == 4'b0110) ? LDR1 : STR1;
      LDR1:      if (mem.mem_resp) state_d = LDR2;
      LDR2:      state_d = FETCH1;
      STR1:      state_d = STR2;
      STR2:      if (mem.mem_resp) state_d = FETCH1;
      default:   state_d = FETCH1;
    endcase

`ifdef MEM_TIMEOUT_EN
    waiting     = (state_q == FETCH2) || (state_q == LDR1) || (state_q == STR2);
    timeout_hit = waiting && !mem.mem_resp && (timer_q == '0);
    if (timeout_hit) state_d = FETCH1;
    timer_d       = (waiting && (state_d == state_q)) ? timer_q - TIMEOUT_W'(1) : TIMER_LOAD;
    mem_timeout_d = mem_timeout_q | timeout_hit;
`endif

    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH1;
      ctrl_q        <= decode_ctrl(FETCH1);
`ifdef MEM_TIMEOUT_EN
      timer_q       <= TIMER_LOAD;
      mem_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
`ifdef MEM_TIMEOUT_EN
      timer_q       <= timer_d;
      mem_timeout_q <= mem_timeout_d;
`endif
    end
  end

  assign load_pc             = ctrl_q.load_pc;
  assign load_ir             = ctrl_q.load_ir;
  assign load_regfile        = ctrl_q.load_regfile;
  assign load_mar            = ctrl_q.load_mar;
  assign load_mdr            = ctrl_q.load_mdr;
  assign load_cc             = ctrl_q.load_cc;
  assign pcmux_sel           = ctrl_q.pcmux_sel;
  assign storemux_sel        = ctrl_q.storemux_sel;
  assign alumux_sel          = ctrl_q.alumux_sel;
  assign regfilemux_sel      = ctrl_q.regfilemux_sel;
  assign marmux_sel          = ctrl_q.marmux_sel;
  assign mdrmux_sel          = ctrl_q.mdrmux_sel;
  assign aluop               = ctrl_q.aluop;
  assign mem.mem_read        = ctrl_q.mem_read;
  assign mem.mem_write       = ctrl_q.mem_write;
  assign mem.mem_byte_enable = 2'b11;

`ifdef MEM_TIMEOUT_EN
  assign mem_timeout = mem_timeout_q;
`else
  assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_control.sv
// Directed, table-driven bench for the control FSM; observes the full registered
// output vector each cycle and compares it against hand-derived per-state patterns.
module tb_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       br_enable;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic       pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
  logic [2:0] aluop;
  logic       mem_timeout;

  int errors = 0;
  int checks = 0;

  control_if mif ();

  control #(.TIMEOUT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode         (opcode),
    .br_enable      (br_enable),
    .mem            (mif.master),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_regfile   (load_regfile),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_cc        (load_cc),
    .pcmux_sel      (pcmux_sel),
    .storemux_sel   (storemux_sel),
    .alumux_sel     (alumux_sel),
    .regfilemux_sel (regfilemux_sel),
    .marmux_sel     (marmux_sel),
    .mdrmux_sel     (mdrmux_sel),
    .aluop          (aluop),
    .mem_timeout    (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Field order: load_pc ir regfile mar mdr cc | pcmux storemux alumux regfilemux marmux mdrmux | aluop | rd wr | be
  localparam logic [18:0] E_F1   = 19'b1_0_0_1_0_0_0_0_0_0_1_0_000_0_0_11;
  localparam logic [18:0] E_RD   = 19'b0_0_0_0_1_0_0_0_0_0_0_1_000_1_0_11;
  localparam logic [18:0] E_F3   = 19'b0_1_0_0_0_0_0_0_0_0_0_0_000_0_0_11;
  localparam logic [18:0] E_IDLE = 19'b0_0_0_0_0_0_0_0_0_0_0_0_000_0_0_11;
  localparam logic [18:0] E_ADD  = 19'b0_0_1_0_0_1_0_0_0_0_0_0_000_0_0_11;
  localparam logic [18:0] E_AND  = 19'b0_0_1_0_0_1_0_0_0_0_0_0_001_0_0_11;
  localparam logic [18:0] E_NOT  = 19'b0_0_1_0_0_1_0_0_0_0_0_0_010_0_0_11;
  localparam logic [18:0] E_BRT  = 19'b1_0_0_0_0_0_1_0_0_0_0_0_000_0_0_11;
  localparam logic [18:0] E_CALC = 19'b0_0_0_1_0_0_0_0_1_0_0_0_000_0_0_11;
  localparam logic [18:0] E_LDR2 = 19'b0_0_1_0_0_1_0_0_0_1_0_0_000_0_0_11;
  localparam logic [18:0] E_STR1 = 19'b0_0_0_0_1_0_0_1_0_0_0_0_011_0_0_11;
  localparam logic [18:0] E_STR2 = 19'b0_0_0_0_0_0_0_0_0_0_0_0_000_0_1_11;

  typedef struct {
    logic [3:0]  op;
    logic        br;
    logic        resp;
    logic [18:0] exp;
    string       name;
  } row_t;

  row_t rows[$];

  function automatic logic [18:0] obs();
    return {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
            pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
            aluop, mif.mem_read, mif.mem_write, mif.mem_byte_enable};
  endfunction

  task automatic chk_vec(input string name, input logic [18:0] exp);
    logic [18:0] got;
    got = obs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b want %b", name, got, exp);
    end
  endtask

  task automatic chk_to(input string name, input logic exp);
    checks++;
    if (mem_timeout !== exp) begin
      errors++;
      $display("FAIL %s: mem_timeout got %b want %b", name, mem_timeout, exp);
    end
  endtask

  // Inputs apply during the current cycle; expected outputs are those after the next edge.
  task automatic step(input logic [3:0] op, input logic br, input logic resp,
                      input logic [18:0] exp, input string name);
    opcode        = op;
    br_enable     = br;
    mif.mem_resp  = resp;
    @(posedge clk);
    #1;
    chk_vec(name, exp);
  endtask

  task automatic add(input logic [3:0] op, input logic br, input logic resp,
                     input logic [18:0] exp, input string name);
    row_t r;
    r.op = op; r.br = br; r.resp = resp; r.exp = exp; r.name = name;
    rows.push_back(r);
  endtask

  initial begin
    rst_n        = 1'b1;
    opcode       = 4'b0000;
    br_enable    = 1'b0;
    mif.mem_resp = 1'b0;

    // ADD, response on the third FETCH2 cycle
    add(4'b0001, 0, 0, E_F1 ^ E_F1 ^ E_RD, "add_f1");
    add(4'b0001, 0, 0, E_RD,   "add_f2_w1");
    add(4'b0001, 0, 0, E_RD,   "add_f2_w2");
    add(4'b0001, 0, 1, E_F3,   "add_f2_resp");
    add(4'b0001, 0, 0, E_IDLE, "add_f3");
    add(4'b0001, 0, 0, E_ADD,  "add_dec");
    add(4'b0001, 0, 0, E_F1,   "add_exec");
    // AND / NOT, immediate response
    add(4'b0101, 0, 0, E_RD,   "and_f1");
    add(4'b0101, 0, 1, E_F3,   "and_f2");
    add(4'b0101, 0, 0, E_IDLE, "and_f3");
    add(4'b0101, 0, 0, E_AND,  "and_dec");
    add(4'b0101, 0, 0, E_F1,   "and_exec");
    add(4'b1001, 0, 0, E_RD,   "not_f1");
    add(4'b1001, 0, 1, E_F3,   "not_f2");
    add(4'b1001, 0, 0, E_IDLE, "not_f3");
    add(4'b1001, 0, 0, E_NOT,  "not_dec");
    add(4'b1001, 0, 0, E_F1,   "not_exec");
    // BR taken
    add(4'b0000, 1, 0, E_RD,   "brt_f1");
    add(4'b0000, 1, 1, E_F3,   "brt_f2");
    add(4'b0000, 1, 0, E_IDLE, "brt_f3");
    add(4'b0000, 1, 0, E_IDLE, "brt_dec");
    add(4'b0000, 1, 0, E_BRT,  "brt_br");
    add(4'b0000, 0, 0, E_F1,   "brt_taken");
    // BR not taken
    add(4'b0000, 0, 0, E_RD,   "brn_f1");
    add(4'b0000, 0, 1, E_F3,   "brn_f2");
    add(4'b0000, 0, 0, E_IDLE, "brn_f3");
    add(4'b0000, 0, 0, E_IDLE, "brn_dec");
    add(4'b0000, 0, 0, E_F1,   "brn_br");
    // LDR, one wait cycle in LDR1
    add(4'b0110, 0, 0, E_RD,   "ldr_f1");
    add(4'b0110, 0, 1, E_F3,   "ldr_f2");
    add(4'b0110, 0, 0, E_IDLE, "ldr_f3");
    add(4'b0110, 0, 0, E_CALC, "ldr_dec");
    add(4'b0110, 0, 0, E_RD,   "ldr_calc");
    add(4'b0110, 0, 0, E_RD,   "ldr1_wait");
    add(4'b0110, 0, 1, E_LDR2, "ldr1_resp");
    add(4'b0110, 0, 0, E_F1,   "ldr2");
    // STR, stray response in STR1, immediate response in STR2
    add(4'b0111, 0, 0, E_RD,   "str_f1");
    add(4'b0111, 0, 1, E_F3,   "str_f2");
    add(4'b0111, 0, 0, E_IDLE, "str_f3");
    add(4'b0111, 0, 0, E_CALC, "str_dec");
    add(4'b0111, 0, 0, E_STR1, "str_calc");
    add(4'b0111, 0, 1, E_STR2, "str1_stray");
    add(4'b0111, 0, 1, E_F1,   "str2_resp");
    // Unknown opcode as NOP, stray responses in FETCH3/DECODE
    add(4'b1111, 0, 0, E_RD,   "nop_f1");
    add(4'b1111, 0, 1, E_F3,   "nop_f2");
    add(4'b1111, 0, 1, E_IDLE, "nop_f3_stray");
    add(4'b1111, 0, 1, E_F1,   "nop_dec_stray");
    add(4'b1111, 0, 0, E_RD,   "nop_next_f1");
    add(4'b1111, 0, 0, E_RD,   "nop_f2_still_waiting");
    add(4'b1111, 0, 1, E_F3,   "nop_f2_resp");
    add(4'b1111, 0, 0, E_IDLE, "nop_f3");
    add(4'b1111, 0, 0, E_F1,   "nop_dec");

    // Asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #2;
    chk_vec("reset_async", E_F1);
    chk_to("reset_timeout", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (rows[i]) step(rows[i].op, rows[i].br, rows[i].resp, rows[i].exp, rows[i].name);

    // Reset in the middle of a pending LDR1 read
    step(4'b0110, 0, 0, E_RD,   "rst_ldr_f1");
    step(4'b0110, 0, 1, E_F3,   "rst_ldr_f2");
    step(4'b0110, 0, 0, E_IDLE, "rst_ldr_f3");
    step(4'b0110, 0, 0, E_CALC, "rst_ldr_dec");
    step(4'b0110, 0, 0, E_RD,   "rst_ldr1_pending");
    #3 rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_ldr1", E_F1);
    @(posedge clk);
    #1;
    chk_vec("rst_held_over_edge", E_F1);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 0, 0, E_RD,   "rst_release_leaves_f1");
    step(4'b0001, 0, 1, E_F3,   "rst_release_f2");
    step(4'b0001, 0, 0, E_IDLE, "rst_release_f3");
    step(4'b0001, 0, 0, E_ADD,  "rst_release_dec");
    step(4'b0001, 0, 0, E_F1,   "rst_release_add");

    // Response on the last allowed wait cycle, then a long LDR1 wait after a long FETCH2 wait
    step(4'b0110, 0, 0, E_RD, "edge_f1");
    for (int i = 0; i < 14; i++) step(4'b0110, 0, 0, E_RD, "edge_f2_wait");
    step(4'b0110, 0, 1, E_F3, "edge_f2_resp_cycle15");
    chk_to("edge_f2_no_timeout", 1'b0);
    step(4'b0110, 0, 0, E_IDLE, "edge_f3");
    step(4'b0110, 0, 0, E_CALC, "edge_dec");
    step(4'b0110, 0, 0, E_RD,   "edge_calc");
    for (int i = 0; i < 14; i++) step(4'b0110, 0, 0, E_RD, "edge_ldr1_wait");
    step(4'b0110, 0, 1, E_LDR2, "edge_ldr1_resp_cycle15");
    chk_to("edge_ldr1_no_timeout", 1'b0);
    step(4'b0110, 0, 0, E_F1, "edge_ldr2");

    // Memory never answers in FETCH2
    step(4'b0001, 0, 0, E_RD, "to_f1");
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 14; i++) step(4'b0001, 0, 0, E_RD, "to_f2_wait");
    chk_to("to_not_yet", 1'b0);
    step(4'b0001, 0, 0, E_F1, "to_abort_to_f1");
    chk_to("to_set", 1'b1);
    step(4'b0001, 0, 0, E_RD,   "to_after_f1");
    step(4'b0001, 0, 1, E_F3,   "to_after_f2");
    step(4'b0001, 0, 0, E_IDLE, "to_after_f3");
    step(4'b0001, 0, 0, E_ADD,  "to_after_dec");
    chk_to("to_sticky", 1'b1);
    rst_n = 1'b0;
    #1;
    chk_to("to_cleared_by_reset", 1'b0);
    chk_vec("to_reset_state", E_F1);
    @(negedge clk);
    rst_n = 1'b1;
`else
    for (int i = 0; i < 40; i++) step(4'b0001, 0, 0, E_RD, "nowd_f2_wait");
    chk_to("nowd_flag_zero", 1'b0);
    step(4'b0001, 0, 1, E_F3, "nowd_f2_resp");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
